mux_rr_sched: RTL and testbench



---
 rtl/mux_rr_sched_pkg.sv | 31 +++
 rtl/mux_rr_sched_rr_pick3.sv | 29 ++
 rtl/mux_rr_sched.sv | 128 ++++++++++++
 tb/tb_mux_rr_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: select codes, FSM states
// and the select/index helpers used by the picker and the top.
package mux_rr_sched_pkg;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [2:0] sel_to_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_A:   oh = 3'b001;
            SEL_B:   oh = 3'b010;
            SEL_C:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Next requester index modulo 3; an out-of-range index wraps to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick3.sv
// Combinational 3-way round-robin picker: scans req from (last+1) mod 3 and
// returns the first requester found, or SEL_NONE when nobody requests.
module rr_pick3
    import mux_rr_sched_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);

    logic [1:0] w_c0;
    logic [1:0] w_c1;
    logic [1:0] w_c2;

    assign w_c0 = next_idx(last);
    assign w_c1 = next_idx(w_c0);
    assign w_c2 = next_idx(w_c1);
    assign any  = |req;

    // Lowest-priority candidate first so the highest-priority hit wins.
    always_comb begin
        pick = SEL_NONE;
        if (req[w_c2]) pick = w_c2;
        if (req[w_c1]) pick = w_c1;
        if (req[w_c0]) pick = w_c0;
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler owning the select of a 3-input N-bit mux: one-hot
// grants, tenure limited to HOLD cycles, registered mux output with valid.
module mux_rr_sched
    import mux_rr_sched_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [2:0]   req,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [1:0]   s,
    output logic [2:0]   gnt,
    output logic [N-1:0] y,
    output logic         y_vld,
    output logic         busy
);

    localparam int unsigned CW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_sel;
    logic [1:0]     w_sel_nxt;
    logic [2:0]     r_gnt;
    logic [2:0]     w_gnt_nxt;
    logic [1:0]     r_last;
    logic [1:0]     w_last_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [N-1:0]   r_y;
    logic           r_y_vld;

    logic [1:0]     w_pick;
    logic           w_any;
    logic           w_own_req;
    logic           w_end;
    logic [N-1:0]   w_mux;

    rr_pick3 u_pick (
        .req  (req),
        .last (r_last),
        .pick (w_pick),
        .any  (w_any)
    );

    assign w_own_req = |(req & r_gnt);
    assign w_end     = !en || !w_own_req || (r_cnt == CW'(HOLD));

    always_comb begin
        case (r_sel)
            SEL_A:   w_mux = a;
            SEL_B:   w_mux = b;
            SEL_C:   w_mux = c;
            default: w_mux = r_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_NONE;
            r_gnt   <= 3'b000;
            r_last  <= SEL_C;
            r_cnt   <= '0;
            r_y     <= '0;
            r_y_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_mux;
            r_y_vld <= (r_state == ST_GRANT) && w_own_req;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (en && w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_cnt_nxt   = CW'(1);
                end
            end
            ST_GRANT: begin
                if (!w_end) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else if (en && w_any) begin
                    // Back-to-back handoff; a sole remaining owner is re-granted.
                    w_sel_nxt  = w_pick;
                    w_last_nxt = w_pick;
                    w_cnt_nxt  = CW'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = SEL_NONE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = SEL_NONE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_gnt_nxt = sel_to_onehot(w_sel_nxt);
        busy      = (r_state == ST_GRANT);
        s         = r_sel;
        gnt       = r_gnt;
        y         = r_y;
        y_vld     = r_y_vld;
    end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched: a tenure-level reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_mux_rr_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned HOLD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   req;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [1:0]   s;
    logic [2:0]   gnt;
    logic [N-1:0] y;
    logic         y_vld;
    logic         busy;

    mux_rr_sched #(
        .N    (N),
        .HOLD (HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .s     (s),
        .gnt   (gnt),
        .y     (y),
        .y_vld (y_vld),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   gnt;
        logic [1:0]   s;
        logic [N-1:0] y;
        logic         vld;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: owner index 0..2, or -1 when idle.
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_last  = 2;
    logic [N-1:0] m_y     = '0;
    logic         m_vld   = 1'b0;

    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] src(input int idx);
        if (idx == 0) return a;
        if (idx == 1) return b;
        return c;
    endfunction

    task automatic model_step();
        int  p;
        bit  ended;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = 2; m_y = '0; m_vld = 1'b0;
        end else begin
            if (m_owner >= 0) begin
                m_y   = src(m_owner);
                m_vld = req[m_owner];
            end else begin
                m_vld = 1'b0;
            end
            p = rr_pick(req, m_last);
            if (m_owner < 0) begin
                if (en && p >= 0) begin
                    m_owner = p; m_last = p; m_cnt = 1;
                end
            end else begin
                ended = !en || !req[m_owner] || (m_cnt == HOLD);
                if (!ended) begin
                    m_cnt++;
                end else if (en && p >= 0) begin
                    m_owner = p; m_last = p; m_cnt = 1;
                end else begin
                    m_owner = -1; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.gnt  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        e.s    = (m_owner < 0) ? 2'b11 : 2'(m_owner);
        e.y    = m_y;
        e.vld  = m_vld;
        e.busy = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            push_expect();
            #1;
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] q,
                         input logic [N-1:0] da, input logic [N-1:0] db,
                         input logic [N-1:0] dc);
        rst = r; en = e; req = q; a = da; b = db; c = dc;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt",   32'(gnt),   32'(e.gnt));
                check("s",     32'(s),     32'(e.s));
                check("y",     32'(y),     32'(e.y));
                check("y_vld", 32'(y_vld), 32'(e.vld));
                check("busy",  32'(busy),  32'(e.busy));
            end
        end
    end

    initial begin : stim
        // Reset held two cycles with all requesting, then fairness rotation.
        drive(1'b1, 1'b1, 3'b111, 4'h1, 4'h2, 4'h3);
        step(2);
        drive(1'b0, 1'b1, 3'b111, 4'h1, 4'h2, 4'h3);
        step(14);

        // Lone requester b, continuous re-grant across HOLD expiry.
        drive(1'b1, 1'b1, 3'b010, 4'h1, 4'h5, 4'h3);
        step(1);
        drive(1'b0, 1'b1, 3'b010, 4'h1, 4'h5, 4'h3);
        step(11);

        // Owner a drops in its second tenure cycle.
        drive(1'b1, 1'b1, 3'b011, 4'h9, 4'hb, 4'hc);
        step(1);
        drive(1'b0, 1'b1, 3'b011, 4'h9, 4'hb, 4'hc);
        step(2);
        drive(1'b0, 1'b1, 3'b010, 4'h9, 4'hb, 4'hc);
        step(3);

        // Enable drop mid-grant of b, then resume with everyone requesting.
        drive(1'b0, 1'b0, 3'b010, 4'h9, 4'hb, 4'hc);
        step(2);
        drive(1'b0, 1'b1, 3'b111, 4'h9, 4'hb, 4'hc);
        step(3);

        // Reset in the middle of c's tenure.
        drive(1'b1, 1'b1, 3'b111, 4'h9, 4'hb, 4'hc);
        step(1);
        drive(1'b0, 1'b1, 3'b111, 4'h9, 4'hb, 4'hc);
        step(6);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
                  3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            step($urandom_range(1, 4));
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL too_few_checks: got %0d expected at least 12", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
